// File: rtl/bf_pkg.sv
// Shared types for the single-clock Brainfuck sequencer: opcodes,
// sticky error codes and sequencer states.
package bf_pkg;

    typedef enum logic [2:0] {
        OP_INC_PTR  = 3'd0,  // '>'
        OP_DEC_PTR  = 3'd1,  // '<'
        OP_INC      = 3'd2,  // '+'
        OP_DEC      = 3'd3,  // '-'
        OP_OUT      = 3'd4,  // '.'
        OP_IN       = 3'd5,  // ','
        OP_LOOP_BEG = 3'd6,  // '['
        OP_LOOP_END = 3'd7   // ']'
    } opcode_t;

    typedef enum logic [1:0] {
        ERR_NONE      = 2'd0,
        ERR_OVERFLOW  = 2'd1,
        ERR_UNDERFLOW = 2'd2,
        ERR_UNMATCHED = 2'd3
    } err_t;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_SKIP  = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

endpackage

// File: rtl/bf_loop_stack.sv
// LIFO of loop-start program addresses. The core never pushes and pops in
// the same cycle; a push when full or pop when empty is ignored.
module bf_loop_stack #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_data,
    output logic [ADDR_W-1:0] top,
    output logic              full,
    output logic              empty
);
    import bf_pkg::*;

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] mem_r [DEPTH];
    logic [CNT_W-1:0]  count_r;
    logic [CNT_W-1:0]  top_pos_s;

    assign top_pos_s = count_r - CNT_W'(1);
    assign top       = mem_r[top_pos_s[IDX_W-1:0]];
    assign full      = (count_r == DEPTH_C);
    assign empty     = (count_r == CNT_W'(0));

    // Entry storage and occupancy count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= CNT_W'(0);
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= ADDR_W'(0);
            end
        end else if (push && !full) begin
            mem_r[count_r[IDX_W-1:0]] <= push_data;
            count_r <= count_r + CNT_W'(1);
        end else if (pop && !empty) begin
            count_r <= count_r - CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/bf_seq_core.sv
// Brainfuck execution engine: FETCH/EXEC/SKIP/HALT sequencer driving a
// combinational ROM and a 1-cycle-latency RAM, with a hardware loop stack
// and valid/ready byte I/O.
module bf_seq_core #(
    parameter int DATA_W      = 8,
    parameter int DADDR_W     = 8,
    parameter int PADDR_W     = 10,
    parameter int STACK_DEPTH = 16
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic               enable,
    output logic [PADDR_W-1:0] prog_addr,
    input  logic [2:0]         prog_op,
    input  logic               prog_end,
    output logic [DADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0]  ram_rdata,
    output logic [DATA_W-1:0]  ram_wdata,
    output logic               ram_we,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_valid,
    input  logic               out_ready,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               halted,
    output logic [1:0]         err
);
    import bf_pkg::*;

    state_t             state_r, state_s;
    opcode_t            op_r, op_s, rom_op_s;
    err_t               err_r, err_s;
    logic [PADDR_W-1:0] pc_r, pc_s;
    logic [DADDR_W-1:0] ptr_r, ptr_s;
    logic [PADDR_W:0]   depth_r, depth_s;
    logic [PADDR_W:0]   pc_inc_s;
    logic               halted_r;
    logic               adv_s;
    state_t             adv_to_s;
    logic               push_s, pop_s;
    logic [PADDR_W-1:0] top_s;
    logic               full_s, empty_s;

    bf_loop_stack #(.ADDR_W(PADDR_W), .DEPTH(STACK_DEPTH)) u_stack (
        .clk(clk), .rst_n(nrst), .push(push_s), .pop(pop_s),
        .push_data(pc_r), .top(top_s), .full(full_s), .empty(empty_s)
    );

    assign rom_op_s  = opcode_t'(prog_op);
    assign pc_inc_s  = {1'b0, pc_r} + (PADDR_W+1)'(1);
    assign prog_addr = pc_r;
    assign ram_addr  = ptr_r;
    assign out_data  = ram_rdata;
    assign halted    = halted_r;
    assign err       = err_r;

    // Next-state, datapath updates and strobes for the current state.
    always_comb begin
        state_s   = state_r;
        op_s      = op_r;
        err_s     = err_r;
        pc_s      = pc_r;
        ptr_s     = ptr_r;
        depth_s   = depth_r;
        adv_s     = 1'b0;
        adv_to_s  = ST_FETCH;
        push_s    = 1'b0;
        pop_s     = 1'b0;
        ram_we    = 1'b0;
        ram_wdata = DATA_W'(0);
        out_valid = 1'b0;
        in_ready  = 1'b0;

        case (state_r)
            ST_FETCH: begin
                if (prog_end) begin
                    state_s = ST_HALT;
                end else if (enable) begin
                    op_s    = rom_op_s;
                    state_s = ST_EXEC;
                end else begin
                    state_s = ST_FETCH;
                end
            end
            ST_EXEC: begin
                case (op_r)
                    OP_INC_PTR: begin
                        ptr_s = ptr_r + DADDR_W'(1);
                        adv_s = 1'b1;
                    end
                    OP_DEC_PTR: begin
                        ptr_s = ptr_r - DADDR_W'(1);
                        adv_s = 1'b1;
                    end
                    OP_INC: begin
                        ram_we    = 1'b1;
                        ram_wdata = ram_rdata + DATA_W'(1);
                        adv_s     = 1'b1;
                    end
                    OP_DEC: begin
                        ram_we    = 1'b1;
                        ram_wdata = ram_rdata - DATA_W'(1);
                        adv_s     = 1'b1;
                    end
                    OP_OUT: begin
                        out_valid = 1'b1;
                        adv_s     = out_ready;
                    end
                    OP_IN: begin
                        in_ready = 1'b1;
                        if (in_valid) begin
                            ram_we    = 1'b1;
                            ram_wdata = in_data;
                            adv_s     = 1'b1;
                        end else begin
                            adv_s = 1'b0;
                        end
                    end
                    OP_LOOP_BEG: begin
                        if (ram_rdata == DATA_W'(0)) begin
                            depth_s  = (PADDR_W+1)'(1);
                            adv_to_s = ST_SKIP;
                            adv_s    = 1'b1;
                        end else if (full_s) begin
                            err_s   = ERR_OVERFLOW;
                            state_s = ST_HALT;
                        end else begin
                            push_s = 1'b1;
                            adv_s  = 1'b1;
                        end
                    end
                    OP_LOOP_END: begin
                        if (empty_s) begin
                            err_s   = ERR_UNDERFLOW;
                            state_s = ST_HALT;
                        end else if (ram_rdata != DATA_W'(0)) begin
                            // top < pc, so top+1 cannot wrap.
                            pc_s    = top_s + PADDR_W'(1);
                            state_s = ST_FETCH;
                        end else begin
                            pop_s = 1'b1;
                            adv_s = 1'b1;
                        end
                    end
                    default: begin
                        state_s = ST_HALT;
                    end
                endcase
            end
            ST_SKIP: begin
                if (prog_end) begin
                    err_s   = ERR_UNMATCHED;
                    state_s = ST_HALT;
                end else begin
                    adv_s    = 1'b1;
                    adv_to_s = ST_SKIP;
                    case (rom_op_s)
                        OP_LOOP_BEG: depth_s = depth_r + (PADDR_W+1)'(1);
                        OP_LOOP_END: begin
                            depth_s = depth_r - (PADDR_W+1)'(1);
                            if (depth_r == (PADDR_W+1)'(1)) begin
                                adv_to_s = ST_FETCH;
                            end else begin
                                adv_to_s = ST_SKIP;
                            end
                        end
                        default: depth_s = depth_r;
                    endcase
                end
            end
            ST_HALT: begin
                state_s = ST_HALT;
            end
            default: begin
                state_s = ST_HALT;
            end
        endcase

        // Common pc advance; running off the top of the ROM space halts.
        if (adv_s) begin
            if (pc_inc_s[PADDR_W]) begin
                state_s = ST_HALT;
            end else begin
                pc_s    = pc_inc_s[PADDR_W-1:0];
                state_s = adv_to_s;
            end
        end else begin
            pc_s = pc_s;
        end
    end

    // Sequencer registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_r  <= ST_FETCH;
            op_r     <= OP_INC_PTR;
            err_r    <= ERR_NONE;
            pc_r     <= PADDR_W'(0);
            ptr_r    <= DADDR_W'(0);
            depth_r  <= (PADDR_W+1)'(0);
            halted_r <= 1'b0;
        end else begin
            state_r  <= state_s;
            op_r     <= op_s;
            err_r    <= err_s;
            pc_r     <= pc_s;
            ptr_r    <= ptr_s;
            depth_r  <= depth_s;
            halted_r <= (state_s == ST_HALT);
        end
    end

endmodule
